dac_mem_writer: RTL and testbench



---
 rtl/dac_mem_writer.sv | 156 +++++++++++++++
 tb/tb_dac_mem_writer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_mem_writer.sv
// Packs the serial stream into bytes and writes them checkerboard-style into eight 32x8 banks.
// Define DAC_LSB_FIRST_EN to pack LSB-first instead of MSB-first.
module dac_mem_writer #(
    parameter logic [7:0] FILL_VALUE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       so_data,
    input  logic       so_valid,
    input  logic       stream_end,
    output logic [7:0] oem_dataout,
    output logic [4:0] oem_addr,
    output logic       odd1_wr,
    output logic       odd2_wr,
    output logic       odd3_wr,
    output logic       odd4_wr,
    output logic       even1_wr,
    output logic       even2_wr,
    output logic       even3_wr,
    output logic       even4_wr,
    output logic       oem_finish
);

    typedef enum logic [2:0] {
        S_RECV,
        S_FLUSH,
        S_FILL_WR,
        S_FILL_GAP,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_shift;
    logic [2:0]  r_bit_cnt;
    logic [8:0]  r_byte_idx;
    logic [7:0]  r_data;
    logic [4:0]  r_addr;
    logic [3:0]  r_odd_wr;
    logic [3:0]  r_even_wr;
    logic        r_finish;

    logic        w_accept;
    logic        w_byte_done;
    logic [2:0]  w_bit_cnt_nx;
    logic [7:0]  w_shift_nx;
    logic [2:0]  w_pad;
    logic [7:0]  w_partial;
    logic        w_wr_en;
    logic [7:0]  w_wr_data;
    logic        w_odd;
    logic [3:0]  w_bank_sel;

    assign w_accept     = (r_state == S_RECV) && !r_byte_idx[8] && so_valid;
    assign w_byte_done  = w_accept && (r_bit_cnt == 3'd7);
    assign w_bit_cnt_nx = w_accept ? r_bit_cnt + 3'd1 : r_bit_cnt;
    assign w_pad        = 3'd0 - r_bit_cnt;

`ifdef DAC_LSB_FIRST_EN
    assign w_shift_nx = {so_data, r_shift[7:1]};
    assign w_partial  = r_shift >> w_pad;
`else
    assign w_shift_nx = {r_shift[6:0], so_data};
    assign w_partial  = r_shift << w_pad;
`endif

    // Checkerboard: odd bank when row and column parities match
    assign w_odd      = ~(r_byte_idx[3] ^ r_byte_idx[0]);
    assign w_bank_sel = 4'b0001 << r_byte_idx[7:6];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_RECV;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_RECV: begin
                if (r_byte_idx[8])
                    w_next = S_DONE;
                else if (stream_end)
                    w_next = (w_bit_cnt_nx != 3'd0) ? S_FLUSH : S_FILL_GAP;
            end
            S_FLUSH:    w_next = S_FILL_GAP;
            S_FILL_WR:  w_next = S_FILL_GAP;
            S_FILL_GAP: w_next = r_byte_idx[8] ? S_DONE : S_FILL_WR;
            S_DONE:     w_next = S_DONE;
            default:    w_next = S_RECV;
        endcase
    end

    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_data = r_data;
        unique case (r_state)
            S_RECV: begin
                w_wr_en   = w_byte_done;
                w_wr_data = w_shift_nx;
            end
            S_FLUSH: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_partial;
            end
            S_FILL_WR: begin
                w_wr_en   = 1'b1;
                w_wr_data = FILL_VALUE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_data     <= '0;
            r_addr     <= '0;
            r_odd_wr   <= '0;
            r_even_wr  <= '0;
            r_finish   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shift   <= w_shift_nx;
                r_bit_cnt <= w_bit_cnt_nx;
            end
            if (r_state == S_FLUSH)
                r_bit_cnt <= '0;
            r_odd_wr  <= '0;
            r_even_wr <= '0;
            if (w_wr_en) begin
                r_byte_idx <= r_byte_idx + 9'd1;
                r_data     <= w_wr_data;
                r_addr     <= r_byte_idx[5:1];
                if (w_odd) r_odd_wr  <= w_bank_sel;
                else       r_even_wr <= w_bank_sel;
            end
            if (w_next == S_DONE)
                r_finish <= 1'b1;
        end
    end

    assign oem_dataout = r_data;
    assign oem_addr    = r_addr;
    assign odd1_wr     = r_odd_wr[0];
    assign odd2_wr     = r_odd_wr[1];
    assign odd3_wr     = r_odd_wr[2];
    assign odd4_wr     = r_odd_wr[3];
    assign even1_wr    = r_even_wr[0];
    assign even2_wr    = r_even_wr[1];
    assign even3_wr    = r_even_wr[2];
    assign even4_wr    = r_even_wr[3];
    assign oem_finish  = r_finish;

endmodule

// File: tb/tb_dac_mem_writer.sv
// Bench for dac_mem_writer: stream-level write scoreboard plus directed literal checks.
// Build with DAC_LSB_FIRST_EN defined to exercise LSB-first packing.
module tb_dac_mem_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       so_data = 1'b0;
    logic       so_valid = 1'b0;
    logic       stream_end = 1'b0;
    logic [7:0] oem_dataout;
    logic [4:0] oem_addr;
    logic       odd1_wr, odd2_wr, odd3_wr, odd4_wr;
    logic       even1_wr, even2_wr, even3_wr, even4_wr;
    logic       oem_finish;
    logic [7:0] stb;

    dac_mem_writer #(.FILL_VALUE(8'h00)) dut (
        .clk(clk), .reset(reset), .so_data(so_data), .so_valid(so_valid),
        .stream_end(stream_end), .oem_dataout(oem_dataout), .oem_addr(oem_addr),
        .odd1_wr(odd1_wr), .odd2_wr(odd2_wr), .odd3_wr(odd3_wr), .odd4_wr(odd4_wr),
        .even1_wr(even1_wr), .even2_wr(even2_wr), .even3_wr(even3_wr),
        .even4_wr(even4_wr), .oem_finish(oem_finish)
    );

    always #5 clk = ~clk;

    // {even4..even1, odd4..odd1}
    assign stb = {even4_wr, even3_wr, even2_wr, even1_wr,
                  odd4_wr, odd3_wr, odd2_wr, odd1_wr};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Model: queue of expected writes, derived from the bit stream
    int         q_idx[$];
    logic [7:0] q_dat[$];
    int         m_idx;
    int         m_nbits;
    logic [7:0] m_b;
    int         seen;
    logic [4:0] last_addr;
    logic [7:0] last_data;
    bit         mon_en = 1'b0;

    function automatic logic [7:0] pack(input logic [7:0] b);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) begin
`ifdef DAC_LSB_FIRST_EN
            v[i] = b[i];
`else
            v[7-i] = b[i];
`endif
        end
        return v;
    endfunction

    function automatic logic [7:0] map_stb(input int n);
        int g, r, c;
        g = n / 64;
        r = (n / 8) % 8;
        c = n % 8;
        if (((r + c) % 2) == 0) return 8'h01 << g;
        else                    return 8'h10 << g;
    endfunction

    task automatic push(input int n, input logic [7:0] d);
        q_idx.push_back(n);
        q_dat.push_back(d);
    endtask

    task automatic model_clear();
        q_idx.delete();
        q_dat.delete();
        m_idx = 0; m_nbits = 0; m_b = '0;
        seen = 0; last_addr = '0; last_data = '0;
    endtask

    task automatic model_bit(input logic d);
        if (m_idx < 256) begin
            m_b[m_nbits] = d;
            m_nbits++;
            if (m_nbits == 8) begin
                push(m_idx, pack(m_b));
                m_idx++; m_nbits = 0; m_b = '0;
            end
        end
    endtask

    task automatic model_end();
        if (m_idx < 256) begin
            if (m_nbits > 0) begin
                push(m_idx, pack(m_b));
                m_idx++; m_nbits = 0; m_b = '0;
            end
            while (m_idx < 256) begin
                push(m_idx, 8'h00);
                m_idx++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            int         n;
            logic [7:0] d;
            check("one_hot", ($countones(stb) <= 1), 1);
            check("finish", oem_finish, (seen == 256));
            if (stb != 0) begin
                if (q_idx.size() == 0) begin
                    check("unexpected_strobe", stb, 0);
                end else begin
                    n = q_idx.pop_front();
                    d = q_dat.pop_front();
                    check($sformatf("wr_stb[%0d]", n), stb, map_stb(n));
                    check($sformatf("wr_addr[%0d]", n), oem_addr, (n % 64) / 2);
                    check($sformatf("wr_data[%0d]", n), oem_dataout, d);
                    last_addr = oem_addr;
                    last_data = oem_dataout;
                    seen++;
                end
            end else begin
                check("hold_addr", oem_addr, last_addr);
                check("hold_data", oem_dataout, last_data);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic d);
        so_valid = 1'b1;
        so_data  = d;
        @(posedge clk);
        #1;
        so_valid = 1'b0;
        so_data  = 1'b0;
        model_bit(d);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) idle(gap);
`ifdef DAC_LSB_FIRST_EN
            send_bit(v[i]);
`else
            send_bit(v[7-i]);
`endif
        end
    endtask

    task automatic end_stream();
        stream_end = 1'b1;
        @(posedge clk);
        #1;
        stream_end = 1'b0;
        model_end();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(2);
        model_clear();
        reset = 1'b0;
    endtask

    task automatic check_wr(input string name, input logic [7:0] s,
                            input logic [4:0] a, input logic [7:0] d);
        check({name, "_stb"}, stb, s);
        check({name, "_addr"}, oem_addr, a);
        check({name, "_data"}, oem_dataout, d);
    endtask

    initial begin
        int fills, consec, cyc;
        bit prev;
        model_clear();
        idle(3);
        check_wr("reset", 8'h00, 5'd0, 8'h00);
        check("reset_finish", oem_finish, 0);
        reset = 1'b0;
        mon_en = 1'b1;

        // Single byte A5
        send_byte(8'hA5, 0);
        check_wr("a5", 8'h01, 5'd0, 8'hA5);
        do_reset();

        // Short stream: 3 bits, flush, fill
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        end_stream();
        idle(1);
`ifdef DAC_LSB_FIRST_EN
        check_wr("flush", 8'h01, 5'd0, 8'h07);
`else
        check_wr("flush", 8'h01, 5'd0, 8'hE0);
`endif
        fills = 0; consec = 0; prev = 1'b1; cyc = 0;
        while (!oem_finish && cyc < 1200) begin
            idle(1);
            cyc++;
            if (stb != 0) begin
                fills++;
                if (prev) consec++;
            end
            prev = (stb != 0);
        end
        check("fill_finish", oem_finish, 1);
        check("fill_count", fills, 255);
        check("fill_back_to_back", consec, 0);
        end_stream();
        idle(4);
        check("done_ignores_end", stb, 0);
        do_reset();

        // 256 continuous bytes, byte n = n
        for (int n = 0; n < 256; n++) begin
            send_byte(n[7:0], 0);
            case (n)
                1:   check_wr("b1",   8'h10, 5'd0,  8'h01);
                8:   check_wr("b8",   8'h10, 5'd4,  8'h08);
                9:   check_wr("b9",   8'h01, 5'd4,  8'h09);
                64:  check_wr("b64",  8'h02, 5'd0,  8'h40);
                255: check_wr("b255", 8'h08, 5'd31, 8'hFF);
                default: ;
            endcase
        end
        send_bit(1'b1);
        check("full_finish", oem_finish, 1);
        check("full_stb_after", stb, 0);
        send_byte(8'hFF, 0);
        check("full_ignore_valid", stb, 0);
        do_reset();

        // Gapped input, one bit every 3 cycles
        send_byte(8'h00, 2);
        check_wr("gap_b0", 8'h01, 5'd0, 8'h00);
        send_byte(8'h01, 2);
        check_wr("gap_b1", 8'h10, 5'd0, 8'h01);
        idle(3);
        check("gap_idle_stb", stb, 0);
        do_reset();

        // Reset in the middle of the fill
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        end_stream();
        cyc = 0;
        while (seen < 100 && cyc < 400) begin
            idle(1);
            cyc++;
        end
        check("midfill_reached", seen, 100);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_wr("midfill_rst", 8'h00, 5'd0, 8'h00);
        check("midfill_rst_finish", oem_finish, 0);
        model_clear();
        reset = 1'b0;
        send_byte(8'h3C, 0);
        check_wr("after_rst", 8'h01, 5'd0, 8'h3C);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
